// File: rtl/adder_measurement_sequencer.sv
// adder_measurement_sequencer
//   Autonomous control sequence for the instrumented adder measurement
//   interface. It takes one command, steps the adder through reset, load,
//   settle, run and capture, and returns the ring count and sum.
//   Optional build macro: SEQ_WATCHDOG_EN adds a RUN-state cycle limit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | defaults driven, cmd_ready=1, waiting for a command
//   SETUP   | dut_reset held for RESET_CYCLES, latched config driven
//   LOAD    | one-cycle counter load pulse
//   SETTLE  | SETTLE_CYCLES gap before ring enable (zero time -> CAPTURE)
//   RUN     | ring running, waiting for dut_done (or watchdog)
//   CAPTURE | ring stopped for CAPTURE_CYCLES, sample on last cycle
//   RESULT  | res_valid=1 until res_ready
module adder_measurement_sequencer #(
  parameter int unsigned RESET_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned CAPTURE_CYCLES  = 2,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_config,
  input  logic [31:0] cmd_integration_time,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_count,
  output logic [7:0]  res_sum,
  output logic        res_error,
  output logic        res_timeout,
  output logic        busy,
  output logic        dut_reset,
  output logic        dut_stop_b,
  output logic        dut_extra_inverter,
  output logic        dut_bypass_b,
  output logic        dut_control_b,
  output logic        dut_counter_enable,
  output logic        dut_counter_load,
  output logic [7:0]  dut_a_ext_bit_b,
  output logic [7:0]  dut_a_ring_bit_b,
  output logic [7:0]  dut_s_bit_b,
  output logic [31:0] dut_integration_time,
  output logic [7:0]  dut_a_input,
  output logic [7:0]  dut_b_input,
  input  logic [7:0]  dut_sum,
  input  logic        dut_done,
  input  logic [31:0] dut_count
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, SETTLE, RUN, CAPTURE, RESULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic        err_q, err_d;

  // cmd_config[1] is ignored (the sequencer owns stop_b), as are [0] and [7:5]
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cmd_config[1:0], cmd_config[7:5]};

`ifdef SEQ_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;
  logic        to_q, to_d;
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^WATCHDOG_CYCLES;
  assign res_timeout     = 1'b0;
`endif

  // state, down-counter timer and sticky flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      err_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  // next-state, timer reload on entry to each timed state, terminal-count exit
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
`ifdef SEQ_WATCHDOG_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = SETUP;
          tmr_d   = 32'(RESET_CYCLES - 1);
          err_d   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
          to_d    = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (tmr_q == '0) state_d = LOAD;
        else             tmr_d   = tmr_q - 32'd1;
      end
      LOAD: begin
        state_d = SETTLE;
        tmr_d   = 32'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 32'd1;
        end else if (dut_integration_time == '0) begin
          state_d = CAPTURE;
          tmr_d   = 32'(CAPTURE_CYCLES - 1);
          err_d   = 1'b1;
        end else begin
          state_d = RUN;
`ifdef SEQ_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      RUN: begin
        if (dut_done) begin
          state_d = CAPTURE;
          tmr_d   = 32'(CAPTURE_CYCLES - 1);
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_q == WATCHDOG_CYCLES - 32'd1) begin
          state_d = CAPTURE;
          tmr_d   = 32'(CAPTURE_CYCLES - 1);
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + 32'd1;
        end
`endif
      end
      CAPTURE: begin
        if (tmr_q == '0) state_d = RESULT;
        else             tmr_d   = tmr_q - 32'd1;
      end
      RESULT: begin
        if (res_valid && res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // registered outputs decoded from the next state so they line up with state_q
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready            <= 1'b1;
      busy                 <= 1'b0;
      res_valid            <= 1'b0;
      res_count            <= '0;
      res_sum              <= '0;
      res_error            <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      res_timeout          <= 1'b0;
`endif
      dut_reset            <= 1'b1;
      dut_stop_b           <= 1'b0;
      dut_counter_enable   <= 1'b0;
      dut_counter_load     <= 1'b0;
      dut_extra_inverter   <= 1'b0;
      dut_bypass_b         <= 1'b1;
      dut_control_b        <= 1'b1;
      dut_a_ext_bit_b      <= 8'hFF;
      dut_a_ring_bit_b     <= 8'hFF;
      dut_s_bit_b          <= 8'hFF;
      dut_integration_time <= '0;
      dut_a_input          <= '0;
      dut_b_input          <= '0;
    end else begin
      cmd_ready          <= (state_d == IDLE);
      busy               <= (state_d != IDLE);
      res_valid          <= (state_d == RESULT);
      dut_reset          <= (state_d == IDLE) || (state_d == SETUP);
      dut_counter_load   <= (state_d == LOAD);
      dut_stop_b         <= (state_d == RUN);
      dut_counter_enable <= (state_d == RUN);
      if (state_d == IDLE) begin
        res_count            <= '0;
        res_sum              <= '0;
        res_error            <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
        res_timeout          <= 1'b0;
`endif
        dut_extra_inverter   <= 1'b0;
        dut_bypass_b         <= 1'b1;
        dut_control_b        <= 1'b1;
        dut_a_ext_bit_b      <= 8'hFF;
        dut_a_ring_bit_b     <= 8'hFF;
        dut_s_bit_b          <= 8'hFF;
        dut_integration_time <= '0;
        dut_a_input          <= '0;
        dut_b_input          <= '0;
      end else if (state_q == IDLE) begin
        // the command registers double as the drive registers for the adder
        dut_extra_inverter   <= cmd_config[2];
        dut_bypass_b         <= cmd_config[3];
        dut_control_b        <= cmd_config[4];
        dut_a_ext_bit_b      <= cmd_config[15:8];
        dut_a_ring_bit_b     <= cmd_config[23:16];
        dut_s_bit_b          <= cmd_config[31:24];
        dut_integration_time <= cmd_integration_time;
        dut_a_input          <= cmd_a;
        dut_b_input          <= cmd_b;
      end
      if (state_q == CAPTURE && state_d == RESULT) begin
        res_count   <= err_q ? 32'd0 : dut_count;
        res_sum     <= dut_sum;
        res_error   <= err_q;
`ifdef SEQ_WATCHDOG_EN
        res_timeout <= to_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_measurement_sequencer.sv
// Scoreboard bench for adder_measurement_sequencer: stimulus pushes the
// expected result, a monitor pops and compares when res_valid rises.
module tb_adder_measurement_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_config = '0;
  logic [31:0] cmd_integration_time = '0;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_count;
  logic [7:0]  res_sum;
  logic        res_error, res_timeout, busy;
  logic        dut_reset, dut_stop_b, dut_extra_inverter, dut_bypass_b, dut_control_b;
  logic        dut_counter_enable, dut_counter_load;
  logic [7:0]  dut_a_ext_bit_b, dut_a_ring_bit_b, dut_s_bit_b;
  logic [31:0] dut_integration_time;
  logic [7:0]  dut_a_input, dut_b_input;
  logic [7:0]  dut_sum = '0;
  logic        dut_done;
  logic [31:0] dut_count = '0;

  adder_measurement_sequencer #(.WATCHDOG_CYCLES(32'd50)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_config(cmd_config),
    .cmd_integration_time(cmd_integration_time), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_sum(res_sum), .res_error(res_error), .res_timeout(res_timeout), .busy(busy),
    .dut_reset(dut_reset), .dut_stop_b(dut_stop_b), .dut_extra_inverter(dut_extra_inverter),
    .dut_bypass_b(dut_bypass_b), .dut_control_b(dut_control_b),
    .dut_counter_enable(dut_counter_enable), .dut_counter_load(dut_counter_load),
    .dut_a_ext_bit_b(dut_a_ext_bit_b), .dut_a_ring_bit_b(dut_a_ring_bit_b),
    .dut_s_bit_b(dut_s_bit_b), .dut_integration_time(dut_integration_time),
    .dut_a_input(dut_a_input), .dut_b_input(dut_b_input),
    .dut_sum(dut_sum), .dut_done(dut_done), .dut_count(dut_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // adder model: done rises in the done_after-th cycle of RUN (0 = never)
  int done_after = 0;
  int run_cnt = 0;
  always @(posedge clk) run_cnt <= dut_counter_enable ? run_cnt + 1 : 0;
  assign dut_done = (done_after != 0) && dut_counter_enable && (run_cnt == done_after - 1);

  bit en_seen = 1'b0;
  always @(negedge clk) if (dut_counter_enable) en_seen = 1'b1;

  typedef struct {
    logic [31:0] count;
    logic [7:0]  sum;
    logic        err;
    logic        to;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compare each presented result against the oldest expectation
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (res_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_count", res_count, e.count);
        chk("res_sum", {24'd0, res_sum}, {24'd0, e.sum});
        chk("res_error", {31'd0, res_error}, {31'd0, e.err});
        chk("res_timeout", {31'd0, res_timeout}, {31'd0, e.to});
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev_valid = res_valid;
  end

  task automatic issue(input logic [31:0] cfg, input logic [31:0] it,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit push, input exp_t e_in);
    exp_t e;
    int t;
    e = e_in;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("issue_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_config = cfg;
    cmd_integration_time = it;
    cmd_a = a;
    cmd_b = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e.acc = cyc;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("result_wait", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_sig(input string name, input bit want_en, input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while (((want_en && !dut_counter_enable) || (!want_en && !res_valid)) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) chk(name, 32'd0, 32'd1);
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_dut_reset"}, {31'd0, dut_reset}, 32'd1);
    chk({tag, "_stop_b"}, {31'd0, dut_stop_b}, 32'd0);
    chk({tag, "_enable"}, {31'd0, dut_counter_enable}, 32'd0);
    chk({tag, "_selects"}, {8'd0, dut_a_ext_bit_b, dut_a_ring_bit_b, dut_s_bit_b}, 32'h00FF_FFFF);
    chk({tag, "_bypass_control"}, {30'd0, dut_bypass_b, dut_control_b}, 32'd3);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_defaults("reset");

    // nominal: done after 10 RUN cycles -> latency 19
    dut_count = 32'd1234;
    dut_sum = 8'h10;
    done_after = 10;
    e = '{count: 32'd1234, sum: 8'h10, err: 1'b0, to: 1'b0, lat: 19, acc: 0};
    issue(32'h0201_FE1E, 32'd10, 8'h0F, 8'h01, 1'b1, e);
    @(negedge clk);
    chk("setup_reset", {31'd0, dut_reset}, 32'd1);
    chk("setup_cfg", {29'd0, dut_extra_inverter, dut_bypass_b, dut_control_b}, 32'd7);
    chk("setup_selects", {8'd0, dut_a_ext_bit_b, dut_a_ring_bit_b, dut_s_bit_b}, 32'h00FE_0102);
    chk("setup_operands", {16'd0, dut_a_input, dut_b_input}, 32'h0000_0F01);
    chk("setup_itime", dut_integration_time, 32'd10);
    chk("setup_cmd_ready", {30'd0, cmd_ready, busy}, 32'd1);
    wait_sig("run_wait", 1'b1, 50);
    chk("run_pins", {29'd0, dut_reset, dut_stop_b, dut_counter_load}, 32'd2);
    wait_empty(60);

    // backpressure: done after 3 -> latency 12, res_ready low 5 cycles
    res_ready = 1'b0;
    dut_count = 32'd5678;
    dut_sum = 8'hAA;
    done_after = 3;
    e = '{count: 32'd5678, sum: 8'hAA, err: 1'b0, to: 1'b0, lat: 12, acc: 0};
    issue(32'h8040_7F00, 32'd3, 8'hA0, 8'h0A, 1'b1, e);
    @(negedge clk);
    chk("cfg2_pins", {29'd0, dut_extra_inverter, dut_bypass_b, dut_control_b}, 32'd0);
    wait_sig("result_wait_bp", 1'b0, 50);
    dut_count = 32'd1;
    dut_sum = 8'h01;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_count", res_count, 32'd5678);
      chk("bp_hold", {29'd0, res_valid, cmd_ready, busy}, 32'd5);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {29'd0, res_valid, cmd_ready, busy}, 32'd2);
    @(negedge clk);
    chk("bp_no_second", {31'd0, busy}, 32'd0);
    wait_empty(10);

    // zero integration time: RUN skipped, latency 9
    dut_count = 32'd999;
    dut_sum = 8'h55;
    done_after = 1;
    en_seen = 1'b0;
    e = '{count: 32'd0, sum: 8'h55, err: 1'b1, to: 1'b0, lat: 9, acc: 0};
    issue(32'h0000_0000, 32'd0, 8'h11, 8'h22, 1'b1, e);
    wait_empty(60);
    chk("zero_no_run", {31'd0, en_seen}, 32'd0);

    // reset during RUN aborts, then a normal command completes
    done_after = 0;
    e = '{count: 32'd0, sum: 8'h00, err: 1'b0, to: 1'b0, lat: 0, acc: 0};
    issue(32'h0102_0304, 32'd7, 8'h01, 8'h02, 1'b0, e);
    wait_sig("abort_run_wait", 1'b1, 50);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_defaults("abort");
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_no_result", {31'd0, res_valid}, 32'd0);
    dut_count = 32'd4321;
    dut_sum = 8'h33;
    done_after = 10;
    e = '{count: 32'd4321, sum: 8'h33, err: 1'b0, to: 1'b0, lat: 19, acc: 0};
    issue(32'h0201_FE00, 32'd10, 8'h30, 8'h03, 1'b1, e);
    wait_empty(60);

    // dut_done never rises
    done_after = 0;
    dut_count = 32'd77;
    dut_sum = 8'h07;
`ifdef SEQ_WATCHDOG_EN
    e = '{count: 32'd77, sum: 8'h07, err: 1'b0, to: 1'b1, lat: 59, acc: 0};
    issue(32'h0201_FE00, 32'd10, 8'h01, 8'h01, 1'b1, e);
    wait_empty(120);
`else
    e = '{count: 32'd0, sum: 8'h00, err: 1'b0, to: 1'b0, lat: 0, acc: 0};
    issue(32'h0201_FE00, 32'd10, 8'h01, 8'h01, 1'b0, e);
    repeat (100) @(negedge clk);
    chk("stuck_busy", {30'd0, busy, res_valid}, 32'd2);
    chk("stuck_running", {31'd0, dut_counter_enable}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
